stage_if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a decoupled prefetch buffer. It replaces the fetch–wait–done lockstep of the previous fetch stage with three pieces: continuous sequential fetching into a small FIFO, a valid/ready handshake towards decode, and a single-cycle redirect port for branches, jumps and traps. It sits between the instruction memory channel and the decode stage of the pipelined core.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/stage_if_prefetch.sv | 116 +++++++++++
 tb/tb_stage_if_prefetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline stages: FSM state encodings and the
// canonical no-op instruction.
package cpu_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] fetch_state_t;

    // One-hot, same style as the other pipeline stage FSMs
    localparam fetch_state_t S_IF   = 3'b001;
    localparam fetch_state_t S_IW   = 3'b010;
    localparam fetch_state_t S_DROP = 3'b100;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and a single-cycle flush.
// Head data is read straight from the storage array (no bypass).
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop in the same cycle
    assign do_push = push && !flush && (count != CNT_W'(DEPTH));
    assign do_pop  = pop  && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: sequential prefetch into a small FIFO, valid/ready
// output towards decode, and a single-cycle redirect for branches and traps.
module stage_if_prefetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   PC,
    output logic                Inst_Req_Valid,
    input  logic                Inst_Req_Ready,
    input  logic [INST_W-1:0]   Instruction,
    input  logic                Inst_Valid,
    output logic                Inst_Ready,
    output logic [INST_W-1:0]   IR,
    output logic [ADDR_W-1:0]   IR_PC,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    input  logic                Redirect_Valid,
    input  logic [ADDR_W-1:0]   Redirect_PC,
    output logic [STATE_W-1:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A raised valid holds with stable payload until accepted; only a
    // redirect (or reset) may withdraw Inst_Req_Valid.

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FW    = INST_W + ADDR_W;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  count;
    logic [FW-1:0]     head;
    logic              has_room;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              unused_redirect_bits;

    // Room is checked at issue, so the slot for the response is reserved
    assign has_room = count < CNT_W'(DEPTH);
    assign req_fire = Inst_Req_Valid && Inst_Req_Ready;
    assign push     = (state == S_IW) && Inst_Valid && !Redirect_Valid;
    assign pop      = Out_Valid && Out_Ready;

    assign unused_redirect_bits = ^Redirect_PC[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IF: begin
                if (req_fire) state_next = S_IW;
            end
            S_IW: begin
                if (Inst_Valid)          state_next = S_IF;
                else if (Redirect_Valid) state_next = S_DROP;
            end
            S_DROP: begin
                if (Inst_Valid) state_next = S_IF;
            end
            default: state_next = S_IF;
        endcase
    end

    always_comb begin
        Inst_Req_Valid = 1'b0;
        Inst_Ready     = 1'b0;
        case (state)
            S_IF:        Inst_Req_Valid = has_room && !Redirect_Valid && !rst;
            S_IW, S_DROP: Inst_Ready    = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                 PC <= RESET_PC;
        else if (Redirect_Valid) PC <= {Redirect_PC[ADDR_W-1:2], 2'b00};
        else if (req_fire)       PC <= PC + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst)           req_pc <= RESET_PC;
        else if (req_fire) req_pc <= PC;
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({Instruction, req_pc}),
        .pop       (pop),
        .flush     (Redirect_Valid),
        .head_data (head),
        .count     (count)
    );

    assign Out_Valid = (count != '0);
    assign IR        = Out_Valid ? head[FW-1:ADDR_W] : INST_W'(INST_NOP);
    assign IR_PC     = head[ADDR_W-1:0];
    assign fsm_state = state;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: directed scenarios plus random traffic against
// a stream-level model (expected fetch addresses and delivered instructions).
module tb_stage_if_prefetch;
    import cpu_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] PC;
    logic              Inst_Req_Valid;
    logic              Inst_Req_Ready = 1'b0;
    logic [INST_W-1:0] Instruction = '0;
    logic              Inst_Valid = 1'b0;
    logic              Inst_Ready;
    logic [INST_W-1:0] IR;
    logic [ADDR_W-1:0] IR_PC;
    logic              Out_Valid;
    logic              Out_Ready = 1'b0;
    logic              Redirect_Valid = 1'b0;
    logic [ADDR_W-1:0] Redirect_PC = '0;
    logic [2:0]        fsm_state;

    stage_if_prefetch #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .PC(PC),
        .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .IR(IR), .IR_PC(IR_PC), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // driver knobs
    logic        drv_rst = 1'b1, drv_redirect = 1'b0, drv_out_ready = 1'b0, drv_req_ready = 1'b0;
    logic [31:0] drv_rpc = '0;
    int          lat_lo = 0, lat_hi = 0;

    // reference model: reserved/delivered addresses in order, next fetch address
    logic [31:0] exp_q[$];
    logic [31:0] exp_req = RESET_PC;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_delay = 0;
    logic        expect_empty = 1'b0, after_rst = 1'b0, prev_rv = 1'b0;

    // observations of the last stepped cycle
    int          n_req = 0;
    logic        last_out_valid, last_req_valid;
    logic [2:0]  last_state;
    logic [31:0] last_acc_pc = '0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic req_acc;
        logic [31:0] e;
        @(negedge clk);
        rst            = drv_rst;
        Redirect_Valid = drv_rst ? 1'b0 : drv_redirect;
        Redirect_PC    = drv_rpc;
        Out_Ready      = drv_out_ready;
        Inst_Req_Ready = drv_req_ready;
        if (!drv_rst && pend && pend_delay == 0) begin
            Inst_Valid  = 1'b1;
            Instruction = mem_word(pend_addr);
        end else begin
            Inst_Valid  = 1'b0;
            Instruction = $urandom;
        end
        if (pend && pend_delay > 0) pend_delay--;
        #1;
        last_out_valid = Out_Valid;
        last_req_valid = Inst_Req_Valid;
        last_state     = fsm_state;
        req_acc        = Inst_Req_Valid && Inst_Req_Ready;
        if (drv_rst) begin
            check("req_valid_in_rst", {63'd0, Inst_Req_Valid}, 64'd0);
            exp_q.delete();
            exp_req      = RESET_PC;
            pend         = 1'b0;
            after_rst    = 1'b1;
            prev_rv      = 1'b0;
            expect_empty = 1'b0;
        end else begin
            if (after_rst) begin
                check("rst_out_valid", {63'd0, Out_Valid}, 64'd0);
                check("rst_pc", {32'd0, PC}, {32'd0, RESET_PC});
                check("rst_state", {61'd0, fsm_state}, {61'd0, S_IF});
                after_rst = 1'b0;
            end
            if (expect_empty) check("empty_after_redirect", {63'd0, Out_Valid}, 64'd0);
            expect_empty = 1'b0;
            if (prev_rv && !Redirect_Valid) check("req_valid_hold", {63'd0, Inst_Req_Valid}, 64'd1);
            if (Inst_Valid) check("inst_ready", {63'd0, Inst_Ready}, 64'd1);
            if (Inst_Req_Valid) check("fifo_room", {63'd0, exp_q.size() < DEPTH}, 64'd1);
            if (Out_Valid && Out_Ready && !Redirect_Valid) begin
                check("pop_has_entry", {63'd0, exp_q.size() > 0}, 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ir_pc", {32'd0, IR_PC}, {32'd0, e});
                    check("ir", {32'd0, IR}, {32'd0, mem_word(e)});
                end
            end
            if (Redirect_Valid) begin
                exp_q.delete();
                exp_req      = {drv_rpc[31:2], 2'b00};
                expect_empty = 1'b1;
            end
            if (req_acc) begin
                check("req_pc", {32'd0, PC}, {32'd0, exp_req});
                check("one_outstanding", {63'd0, pend}, 64'd0);
                exp_q.push_back(PC);
                exp_req     = exp_req + 32'd4;
                last_acc_pc = PC;
                n_req++;
                pend        = 1'b1;
                pend_addr   = PC;
                pend_delay  = $urandom_range(lat_hi, lat_lo);
            end else if (Inst_Valid) begin
                pend = 1'b0;
            end
            prev_rv = Inst_Req_Valid && !req_acc && !Redirect_Valid;
        end
        @(posedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        drv_redirect = 1'b1;
        drv_rpc      = a;
        step();
        drv_redirect = 1'b0;
    endtask

    initial begin
        int base;

        // reset and streaming with a zero-wait memory
        drv_rst = 1'b1; drv_req_ready = 1'b1; drv_out_ready = 1'b1; lat_lo = 0; lat_hi = 0;
        step(); step();
        drv_rst = 1'b0;
        step(); check("first_ov_c0", {63'd0, last_out_valid}, 64'd0);
        step(); check("first_ov_c1", {63'd0, last_out_valid}, 64'd0);
        step(); check("first_ov_c2", {63'd0, last_out_valid}, 64'd1);
        for (int i = 0; i < 20; i++) step();

        // backpressure: exactly DEPTH buffered, then one pop frees exactly one slot
        drv_out_ready = 1'b0;
        redirect_to(32'h0000_3000);
        base = n_req;
        for (int i = 0; i < 20; i++) step();
        check("buffered_count", 64'(n_req - base), 64'(DEPTH));
        check("full_req_valid", {63'd0, last_req_valid}, 64'd0);
        drv_out_ready = 1'b1; step(); drv_out_ready = 1'b0;
        base = n_req;
        for (int i = 0; i < 10; i++) step();
        check("one_more_req", 64'(n_req - base), 64'd1);
        check("refull_req_valid", {63'd0, last_req_valid}, 64'd0);

        // redirect while awaiting a response delayed by 3 cycles
        drv_out_ready = 1'b1; lat_lo = 3; lat_hi = 3;
        redirect_to(32'h0000_4000);
        for (int i = 0; i < 50 && !pend; i++) step();
        check("wait_iw", {63'd0, pend}, 64'd1);
        redirect_to(32'h0000_2002);
        step();
        check("drop_state", {61'd0, last_state}, {61'd0, S_DROP});
        for (int i = 0; i < 20; i++) step();

        // redirect coincident with a response and a pop
        lat_lo = 0; lat_hi = 0; drv_out_ready = 1'b0;
        for (int i = 0; i < 50 && !(pend && pend_delay == 0 && last_out_valid); i++) step();
        check("setup_coincident", {63'd0, pend && pend_delay == 0 && last_out_valid}, 64'd1);
        drv_out_ready = 1'b1;
        redirect_to(32'h0000_5000);
        step();
        check("coincident_state", {61'd0, last_state}, {61'd0, S_IF});
        check("coincident_req_pc", {32'd0, last_acc_pc}, 64'h5000);
        for (int i = 0; i < 10; i++) step();

        // address wrap at the top of the address space
        redirect_to(32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) step();

        // reset with three entries buffered and a request outstanding
        drv_out_ready = 1'b0; lat_lo = 5; lat_hi = 5;
        redirect_to(32'h0000_6000);
        for (int i = 0; i < 80 && !(pend && exp_q.size() == DEPTH); i++) step();
        check("setup_midrst", {63'd0, pend && exp_q.size() == DEPTH}, 64'd1);
        drv_rst = 1'b1; step(); drv_rst = 1'b0;
        step();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            drv_rst       = ($urandom_range(299, 0) == 0);
            drv_redirect  = ($urandom_range(19, 0) == 0);
            drv_rpc       = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                          : $urandom;
            drv_out_ready = ($urandom_range(3, 0) != 0);
            drv_req_ready = ($urandom_range(3, 0) != 0);
            lat_lo = 0; lat_hi = 3;
            step();
        end
        drv_rst = 1'b0; drv_redirect = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
